serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  minuend, unsigned; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-008 done  output  1  single-cycle pulse; diff/bout valid and newly updated.
REQ-009 diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-010 bout  output  1  registered final borrow; 1 iff a < b unsigned.

Function
REQ-011 Computation SHALL be bit-serial, LSB first, one bit per clock, through one full-subtract cell with a 1-bit borrow register.
REQ-012 Per bit: d = ai ^ bi ^ bin; bnext = (~ai & bi) | (~(ai ^ bi) & bin); bin = 0 for bit 0.
REQ-013 FSM states: IDLE, SHIFT, DONE; every other encoding SHALL return to IDLE on the next edge.
REQ-014 IDLE: start=1 -> capture a, b into shift registers, clear borrow, load bit counter with WIDTH, go to SHIFT.
REQ-015 IDLE: start=0 -> remain in IDLE.
REQ-016 SHIFT: each edge processes one bit and decrements the counter; the edge processing the final bit goes to DONE.
REQ-017 DONE: lasts exactly one cycle; then go to IDLE unconditionally.
REQ-018 Latency: start accepted on edge k -> done=1 in the cycle following edge k+WIDTH.
REQ-019 diff and bout SHALL be updated only on the transition into DONE; intermediate bits SHALL NOT be visible.
REQ-020 diff and bout SHALL hold their value until the next transition into DONE.
REQ-021 start while busy=1 (SHIFT or DONE) SHALL be ignored; it is not queued.
REQ-022 After DONE, start SHALL be accepted in the first IDLE cycle; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 Changes on a/b after the accepting edge SHALL NOT affect the result in progress.
REQ-024 WIDTH=1: SHIFT lasts one cycle; done in the cycle after edge k+1.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, diff=0, bout=0, and clear counter, borrow and shift registers.
REQ-026 Reset during SHIFT SHALL abandon the operation; no done pulse follows.
REQ-027 start while rst=1 SHALL be ignored; the first acceptance is possible on the first edge after rst falls.

Structure
REQ-028 Shared package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 Counter width SHALL be $clog2(WIDTH+1) bits, declared in the module from WIDTH.
REQ-030 The per-bit logic SHALL be one combinational sub-module full_sub (ports ai, bi, bin, d, bnext), instantiated once.
REQ-031 Outputs busy and done SHALL be decoded from registered state only; no combinational path from start to any output.

Verification
REQ-032 WIDTH=8, a=5, b=3, start pulse on edge k -> busy high from edge k, done pulse after edge k+8, diff=8'h02, bout=0.
REQ-033 a=3, b=5 -> diff=8'hFE, bout=1; a=0, b=8'hFF -> diff=8'h01, bout=1; a=0, b=0 -> diff=8'h00, bout=0.
REQ-034 a=8'hAA, b=8'h55 accepted, then start=1 with a=1, b=1 held throughout SHIFT -> diff=8'h55, bout=0, exactly one done pulse, and the second op is accepted only in the first IDLE cycle.
REQ-035 rst asserted mid-clock after 3 SHIFT edges -> busy, done, diff, bout read 0 before the next edge; no done pulse follows.
REQ-036 Exhaustive check at WIDTH=4: all 256 (a,b) pairs back-to-back -> diff=(a-b) mod 16, bout=(a<b), done pulses exactly WIDTH+2 cycles apart.
REQ-037 WIDTH=1, a=0, b=1 -> done pulse after edge k+1, diff=1, bout=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full-subtract cell: difference and borrow-out from two operand bits and borrow-in.
module full_sub (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bnext
);

  always_comb begin
    d     = ai ^ bi ^ bin;
    bnext = (~ai & bi) | (~(ai ^ bi) & bin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, bout = (a < b), LSB first, one bit per clock.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_d;
  logic               w_bnext;
  logic [WIDTH-1:0]   w_acc_next;

  full_sub u_full_sub (
    .ai    (r_a[0]),
    .bi    (r_b[0]),
    .bin   (r_borrow),
    .d     (w_d),
    .bnext (w_bnext)
  );

  // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    w_acc_next            = r_acc >> 1;
    w_acc_next[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= CNT_W'(WIDTH);
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_acc    <= w_acc_next;
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt - CNT_W'(1);
          // Results are published only on the final bit so partial sums never appear on diff.
          if (r_cnt == CNT_W'(1)) begin
            r_diff  <= w_acc_next;
            r_bout  <= w_bnext;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == SHIFT) || (r_state == DONE);
    done = (r_state == DONE);
    diff = r_diff;
    bout = r_bout;
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8, 4 and 1: stimulus pushes expectations, monitors pop on done.
module tb_serial_sub;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        bz [3];
  logic        dn [3];
  logic        bo [3];
  logic [7:0]  d8;
  logic [3:0]  d4;
  logic [0:0]  d1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ndone [3] = '{0, 0, 0};
  int lastd = -1;
  bit b2b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .busy(bz[0]), .done(dn[0]), .diff(d8), .bout(bo[0])
  );
  serial_sub #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
    .busy(bz[1]), .done(dn[1]), .diff(d4), .bout(bo[1])
  );
  serial_sub #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st[2]), .a(av[2][0:0]), .b(bv[2][0:0]),
    .busy(bz[2]), .done(dn[2]), .diff(d1), .bout(bo[2])
  );

  function automatic int wid(input int n);
    return (n == 0) ? 8 : (n == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int n, input logic [31:0] d, input logic b, input int acc);
    exp_t e;
    e.d = d; e.bo = b; e.acc = acc;
    case (n)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int n, input logic done_i, input logic [31:0] d, input logic b);
    exp_t e;
    bit   got;
    if (done_i !== 1'b1) return;
    ndone[n]++;
    got = 1'b0;
    case (n)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done inst=%0d: got done=1 expected no done (t=%0t)", n, $time);
      return;
    end
    chk($sformatf("diff_w%0d", wid(n)), d, e.d);
    chk($sformatf("bout_w%0d", wid(n)), 32'(b), 32'(e.bo));
    chk($sformatf("latency_w%0d", wid(n)), 32'(cyc - e.acc), 32'(wid(n)));
    if (n == 1 && b2b) begin
      if (lastd >= 0) chk("spacing_w4", 32'(cyc - lastd), 32'(6));
      lastd = cyc;
    end
  endtask

  always @(negedge clk) mon(0, dn[0], 32'(d8), bo[0]);
  always @(negedge clk) mon(1, dn[1], 32'(d4), bo[1]);
  always @(negedge clk) mon(2, dn[2], 32'(d1), bo[2]);

  // Drive start with operands for one cycle; returns the accepting edge number.
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b, output int acc);
    st[n] = 1'b1; av[n] = a; bv[n] = b;
    @(posedge clk);
    #1;
    st[n] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int n, input int target, input int budget);
    for (int i = 0; i < budget && ndone[n] < target; i++) @(posedge clk);
    #1;
    checks++;
    if (ndone[n] < target) begin
      failures++;
      $display("FAIL done_timeout inst=%0d: got %0d dones expected %0d", n, ndone[n], target);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v8 [3];
    vec_t v1 [3];
    int   acc;
    int   nd;

    v8[0] = '{32'h03, 32'h05, 32'hFE, 1'b1};
    v8[1] = '{32'h00, 32'hFF, 32'h01, 1'b1};
    v8[2] = '{32'h00, 32'h00, 32'h00, 1'b0};
    v1[0] = '{32'h0, 32'h1, 32'h1, 1'b1};
    v1[1] = '{32'h1, 32'h0, 32'h1, 1'b0};
    v1[2] = '{32'h1, 32'h1, 32'h0, 1'b0};

    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; av[i] = '0; bv[i] = '0; end
    rst = 1'b1;
    st[0] = 1'b1; av[0] = 32'd5; bv[0] = 32'd3;
    #2;
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_diff", 32'(d8), 32'd0);
    chk("rst_bout", 32'(bo[0]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("start_in_rst_ignored", 32'(bz[0]), 32'd0);
    rst = 1'b0;

    // 5 - 3, start already high when reset falls
    issue(0, 32'd5, 32'd3, acc);
    push(0, 32'h02, 1'b0, acc);
    chk("busy_after_accept", 32'(bz[0]), 32'd1);
    wait_done(0, 1, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("diff_hold", 32'(d8), 32'h02);

    for (int i = 0; i < 2; i++) begin
      issue(0, v8[i].a, v8[i].b, acc);
      push(0, v8[i].d, v8[i].bo, acc);
      wait_done(0, ndone[0] + 1, 20);
    end

    // Reset mid-operation, outputs clear before the next edge and no done follows
    issue(0, 32'd5, 32'd3, acc);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bz[0]), 32'd0);
    chk("midrst_done", 32'(dn[0]), 32'd0);
    chk("midrst_diff", 32'(d8), 32'd0);
    chk("midrst_bout", 32'(bo[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = ndone[0];
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(ndone[0]), 32'(nd));

    issue(0, v8[2].a, v8[2].b, acc);
    push(0, v8[2].d, v8[2].bo, acc);
    wait_done(0, ndone[0] + 1, 20);

    // AA-55 while start stays high with 1,1 through SHIFT; second op lands in first IDLE cycle
    nd = ndone[0];
    issue(0, 32'hAA, 32'h55, acc);
    push(0, 32'h55, 1'b0, acc);
    st[0] = 1'b1; av[0] = 32'd1; bv[0] = 32'd1;
    push(0, 32'h00, 1'b0, acc + 10);
    repeat (10) @(posedge clk);
    #1;
    st[0] = 1'b0;
    chk("single_done_while_held", 32'(ndone[0]), 32'(nd + 1));
    chk("second_accepted", 32'(bz[0]), 32'd1);
    wait_done(0, nd + 2, 20);

    // Exhaustive WIDTH=4 back-to-back; operands scrambled right after each accept
    b2b = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        st[1] = 1'b1; av[1] = 32'(a); bv[1] = 32'(b);
        @(posedge clk);
        #1;
        push(1, 32'((a - b) & 15), (a < b), cyc);
        av[1] = 32'(~a); bv[1] = 32'(~b);
        repeat (5) @(posedge clk);
        #1;
      end
    end
    st[1] = 1'b0;
    wait_done(1, 256, 40);
    b2b = 1'b0;

    for (int i = 0; i < 3; i++) begin
      issue(2, v1[i].a, v1[i].b, acc);
      push(2, v1[i].d, v1[i].bo, acc);
      wait_done(2, ndone[2] + 1, 10);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q_w8_empty", 32'(q0.size()), 32'd0);
    chk("q_w4_empty", 32'(q1.size()), 32'd0);
    chk("q_w1_empty", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
